data_memory_unit: RTL and testbench

Multi-cycle data-memory stage directly downstream of the 64-bit ALU: it takes the ALU result (`BusW`) as a byte address and the second register operand as store data, and performs one doubleword load or store per request. Access latency is parameterised to model slow memory. The processor is held via `Stall` until a one-cycle `Done` completes each access. Illegal requests are rejected with `Fault` and never touch memory.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_array.sv | 39 +++
 rtl/data_memory_unit.sv | 131 +++++++++++++
 tb/tb_data_memory_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory stage.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic REQ_LOAD  = 1'b0;
  localparam logic REQ_STORE = 1'b1;

  localparam int DWORD_W = 64;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous doubleword RAM; contents are never reset, only the
// read-data register is.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic               re,
  input  logic               clr,
  input  logic [AW-1:0]      addr,
  input  logic [DWORD_W-1:0] wdata,
  output logic [DWORD_W-1:0] rdata
);

  logic [DWORD_W-1:0] mem [DEPTH];

  // Store port: contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read-data register: cleared on a rejected request, otherwise held until the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_memory_unit.sv
// Data-memory stage: legality check, latency counter and access FSM around
// a doubleword RAM. Stall holds the processor until a one-cycle Done.
module data_memory_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [63:0]        Address,
  input  logic [DWORD_W-1:0] WriteData,
  input  logic               MemRead,
  input  logic               MemWrite,
  output logic [DWORD_W-1:0] ReadData,
  output logic               Stall,
  output logic               Done,
  output logic               Fault
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_C = LATENCY[3:0];

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("data_memory_unit: LATENCY must be in 1..15");
  end
  if (DEPTH < 2 || DEPTH > 65536 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("data_memory_unit: DEPTH must be a power of two in 2..65536");
  end

  state_t             state_r;
  logic [3:0]         cnt_r;
  logic [AW-1:0]      addr_r;
  logic [DWORD_W-1:0] wdata_r;
  logic               type_r;
  logic               done_r;
  logic               fault_r;

  logic req_s;
  logic illegal_s;
  logic fire_s;
  logic we_s;
  logic re_s;
  logic clr_s;

  // Request decode, legality and Stall; Address never reaches Stall.
  always_comb begin
    req_s     = MemRead | MemWrite;
    illegal_s = (Address[2:0] != 3'd0) || (Address[63:3] >= 61'(DEPTH)) ||
                (MemRead && MemWrite);
    case (state_r)
      IDLE:    Stall = req_s;
      WAIT:    Stall = 1'b1;
      default: Stall = 1'b0;
    endcase
    fire_s = (state_r == WAIT) && (cnt_r <= 4'd1);
    we_s   = fire_s && (type_r == REQ_STORE);
    re_s   = fire_s && (type_r == REQ_LOAD);
    clr_s  = (state_r == IDLE) && req_s && illegal_s;
  end

  // Access controller: latches the request in IDLE, counts down in WAIT, pulses Done.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= '0;
      wdata_r <= '0;
      type_r  <= REQ_LOAD;
      done_r  <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r  <= 1'b0;
          fault_r <= 1'b0;
          if (req_s) begin
            addr_r  <= Address[3 +: AW];
            wdata_r <= WriteData;
            type_r  <= MemWrite ? REQ_STORE : REQ_LOAD;
            if (illegal_s) begin
              state_r <= DONE;
              done_r  <= 1'b1;
              fault_r <= 1'b1;
            end else begin
              state_r <= WAIT;
              cnt_r   <= LAT_C;
            end
          end
        end
        WAIT: begin
          if (cnt_r <= 4'd1) begin
            cnt_r   <= 4'd0;
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          fault_r <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          fault_r <= 1'b0;
        end
      endcase
    end
  end

  assign Done  = done_r;
  assign Fault = fault_r;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (Clk),
    .rst   (Reset),
    .we    (we_s),
    .re    (re_s),
    .clr   (clr_s),
    .addr  (addr_r),
    .wdata (wdata_r),
    .rdata (ReadData)
  );

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed + random bench for data_memory_unit against an array-based model.
module tb_data_memory_unit;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        Clk;
  logic        Reset;
  logic [63:0] Address, WriteData, ReadData;
  logic        MemRead, MemWrite, Stall, Done, Fault;

  logic [63:0] Address1, WriteData1, ReadData1;
  logic        MemRead1, MemWrite1, Stall1, Done1, Fault1;

  int total = 0;
  int bad   = 0;

  logic [63:0] model [DEPTH];
  logic [63:0] rd_model;
  logic [63:0] val1 [6];
  logic [63:0] a, d, old30;
  int          kind;

  data_memory_unit #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .Clk(Clk), .Reset(Reset), .Address(Address), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData),
    .Stall(Stall), .Done(Done), .Fault(Fault)
  );

  data_memory_unit #(.DEPTH(16), .LATENCY(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .Address(Address1), .WriteData(WriteData1),
    .MemRead(MemRead1), .MemWrite(MemWrite1), .ReadData(ReadData1),
    .Stall(Stall1), .Done(Done1), .Fault(Fault1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete request on dut, called at a negedge of an IDLE cycle.
  task automatic op(input logic rd, input logic wr, input logic [63:0] addr,
                    input logic [63:0] data, input string tag);
    logic legal;
    legal = (addr[2:0] == 3'd0) && (addr[63:3] < 61'(DEPTH)) && !(rd && wr);
    MemRead = rd; MemWrite = wr; Address = addr; WriteData = data;
    #1 chk({tag, "/stall_req"}, 64'(Stall), 64'd1);
    if (legal) begin
      if (wr) model[int'(addr[63:3])] = data;
      else    rd_model = model[int'(addr[63:3])];
    end else begin
      rd_model = 64'd0;
    end
    @(negedge Clk);
    if (legal) begin
      for (int i = 0; i < LAT; i++) begin
        chk({tag, "/stall_wait"}, 64'(Stall), 64'd1);
        chk({tag, "/done_wait"}, 64'(Done), 64'd0);
        Address = {$urandom, $urandom};
        WriteData = {$urandom, $urandom};
        @(negedge Clk);
      end
    end
    chk({tag, "/done"}, 64'(Done), 64'd1);
    chk({tag, "/stall_done"}, 64'(Stall), 64'd0);
    chk({tag, "/fault"}, 64'(Fault), legal ? 64'd0 : 64'd1);
    chk({tag, "/rdata"}, ReadData, rd_model);
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge Clk);
    #1 chk({tag, "/idle_stall"}, 64'(Stall), 64'd0);
    chk({tag, "/idle_done"}, 64'(Done), 64'd0);
  endtask

  initial begin
    Reset = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b0; Address = 64'd0; WriteData = 64'd0;
    MemRead1 = 1'b0; MemWrite1 = 1'b0; Address1 = 64'd0; WriteData1 = 64'd0;
    rd_model = 64'd0;
    repeat (2) @(negedge Clk);
    chk("rst/rdata", ReadData, 64'd0);
    chk("rst/stall", 64'(Stall), 64'd0);
    chk("rst/done", 64'(Done), 64'd0);
    chk("rst/fault", 64'(Fault), 64'd0);
    chk("rst/done1", 64'(Done1), 64'd0);
    Reset = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < DEPTH; i++)
      op(1'b0, 1'b1, {53'd0, 8'(i), 3'd0}, {$urandom, $urandom}, "fill");

    op(1'b0, 1'b1, 64'h10, 64'hDEAD_BEEF_0123_4567, "st10");
    op(1'b1, 1'b0, 64'h10, 64'd0, "ld10");
    chk("ld10/const", ReadData, 64'hDEAD_BEEF_0123_4567);
    op(1'b1, 1'b0, 64'h13, 64'd0, "ld13_mis");
    op(1'b1, 1'b0, 64'h10, 64'd0, "reld10");
    chk("reld10/const", ReadData, 64'hDEAD_BEEF_0123_4567);
    op(1'b1, 1'b0, 64'h800, 64'd0, "ld800_oor");
    op(1'b1, 1'b0, 64'h7F8, 64'd0, "ld7f8");
    op(1'b1, 1'b1, 64'h20, 64'h1111_2222_3333_4444, "both20");
    op(1'b1, 1'b0, 64'h20, 64'd0, "ld20");

    // Reset in the second WAIT cycle of a store to 0x30.
    old30 = model[6];
    op(1'b1, 1'b0, 64'h10, 64'd0, "pre_rst");
    MemWrite = 1'b1; Address = 64'h30; WriteData = ~old30;
    @(negedge Clk);
    chk("rst30/wait1_stall", 64'(Stall), 64'd1);
    @(negedge Clk);
    Reset = 1'b1; MemWrite = 1'b0;
    #1 chk("rst30/rdata", ReadData, 64'd0);
    chk("rst30/stall", 64'(Stall), 64'd0);
    chk("rst30/done", 64'(Done), 64'd0);
    chk("rst30/fault", 64'(Fault), 64'd0);
    rd_model = 64'd0;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    op(1'b1, 1'b0, 64'h30, 64'd0, "ld30");
    chk("ld30/old", ReadData, old30);

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      d = {$urandom, $urandom};
      a = {53'd0, 8'($urandom_range(0, 255)), 3'd0};
      case (kind)
        0, 1, 2, 3: op(1'b1, 1'b0, a, d, "rnd_ld");
        4, 5, 6:    op(1'b0, 1'b1, a, d, "rnd_st");
        7: begin
          a[2:0] = 3'($urandom_range(1, 7));
          op(1'($urandom_range(0, 1)), 1'b1, a, d, "rnd_mis");
        end
        8: begin
          a = {$urandom, $urandom};
          a[2:0] = 3'd0;
          if (a[63:3] < 61'(DEPTH)) a = a | 64'h800;
          op(1'b1, 1'b0, a, d, "rnd_oor");
        end
        default: op(1'b1, 1'b1, a, d, "rnd_both");
      endcase
    end

    // LATENCY=1 instance: request held through DONE for consecutive stores.
    for (int g = 0; g < 6; g++) begin
      val1[g] = {$urandom, $urandom};
      Address1 = (g == 0) ? 64'h78 : 64'(g * 8);
      WriteData1 = val1[g];
      MemWrite1 = 1'b1;
      #1 chk("hold/idle_stall", 64'(Stall1), 64'd1);
      chk("hold/idle_done", 64'(Done1), 64'd0);
      @(negedge Clk);
      chk("hold/wait_stall", 64'(Stall1), 64'd1);
      chk("hold/wait_done", 64'(Done1), 64'd0);
      Address1 = 64'h78; WriteData1 = 64'hBAD0_BAD0_BAD0_BAD0;
      @(negedge Clk);
      chk("hold/done", 64'(Done1), 64'd1);
      chk("hold/done_stall", 64'(Stall1), 64'd0);
      chk("hold/fault", 64'(Fault1), 64'd0);
      @(negedge Clk);
    end
    MemWrite1 = 1'b0;
    for (int g = 0; g < 6; g++) begin
      MemRead1 = 1'b1;
      Address1 = (g == 0) ? 64'h78 : 64'(g * 8);
      @(negedge Clk);
      @(negedge Clk);
      chk("hold/readback_done", 64'(Done1), 64'd1);
      chk("hold/readback", ReadData1, val1[g]);
      MemRead1 = 1'b0;
      @(negedge Clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
